sync_fifo_flags: RTL and testbench

Single-clock, parametrised FIFO; successor to the dual-clock FIFO, for buffering inside one clock domain. Keeps the write/read increment interface and full/empty flags. Adds:
- programmable almost-full/almost-empty thresholds
- occupancy count
- sticky overflow/underflow error flags
- selectable standard or first-word-fall-through (FWFT) read mode

---
 rtl/sync_fifo_flags.sv | 136 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and a selectable
// standard (registered) or first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int data_Size     = 8,
  parameter int address_Size  = 5,
  parameter int AFULL_Thresh  = 28,
  parameter int AEMPTY_Thresh = 4,
  parameter int FWFT          = 0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [data_Size-1:0]    write_Data,
  input  logic                    w_Inc,
  input  logic                    r_Inc,
  input  logic                    clr_Err,
  output logic [data_Size-1:0]    read_Data,
  output logic                    read_Valid,
  output logic                    fifo_Full,
  output logic                    fifo_Empty,
  output logic                    fifo_AlmostFull,
  output logic                    fifo_AlmostEmpty,
  output logic [address_Size:0]   fill_Count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW    = address_Size;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_Thresh);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_Thresh);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  // Thresholds are fixed at build time, so a bad combination is caught
  // before any hardware is produced.
  generate
    if (AFULL_Thresh < 1 || AFULL_Thresh > DEPTH - 1 ||
        AEMPTY_Thresh < 0 || AEMPTY_Thresh > DEPTH - 2 ||
        AEMPTY_Thresh >= AFULL_Thresh) begin : g_bad_thresh
      $fatal(1, "sync_fifo_flags: illegal AFULL_Thresh/AEMPTY_Thresh");
    end
  endgenerate

  logic [data_Size-1:0] r_mem [DEPTH];
  logic [AW:0]          r_wptr;
  logic [AW:0]          r_rptr;
  logic                 r_overflow;
  logic                 r_underflow;

  logic [AW:0]          w_fill;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_ok;
  logic                 w_rd_ok;

  // Occupancy is the pointer distance; the extra pointer bit separates
  // full (distance DEPTH) from empty (distance 0). Everything here decodes
  // from registers, so flags move the cycle after the causing edge.
  assign w_fill  = r_wptr - r_rptr;
  assign w_full  = (w_fill == DEPTH_C);
  assign w_empty = (w_fill == '0);

  // Acceptance is judged on the pre-edge state: no full/empty bypass.
  assign w_wr_ok = w_Inc & ~w_full;
  assign w_rd_ok = r_Inc & ~w_empty;

  // Storage array: written on an accepted write only.
  // NOTE: the array has no reset; reset only clears the pointers, which
  // already marks every entry as invalid, and keeps it mappable to RAM.
  always_ff @(posedge Clk) begin
    if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= write_Data;
  end

  // Write/read pointers advance only on accepted requests.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Sticky error flags: a new error event takes priority over clr_Err.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_Inc && w_full)  r_overflow  <= 1'b1;
      else if (clr_Err)     r_overflow  <= 1'b0;
      if (r_Inc && w_empty) r_underflow <= 1'b1;
      else if (clr_Err)     r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [data_Size-1:0] r_rdata;
      logic                 r_rvalid;

      // Registered read: data appears one cycle after an accepted read and
      // holds afterwards; read_Valid is a single-cycle pulse.
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd_ok;
          if (w_rd_ok) r_rdata <= r_mem[r_rptr[AW-1:0]];
        end
      end

      assign read_Data  = r_rdata;
      assign read_Valid = r_rvalid;
    end else begin : g_fwft
      // Head word is always presented; r_Inc acknowledges it.
      assign read_Data  = r_mem[r_rptr[AW-1:0]];
      assign read_Valid = ~w_empty;
    end
  endgenerate

  assign fill_Count       = w_fill;
  assign fifo_Full        = w_full;
  assign fifo_Empty       = w_empty;
  assign fifo_AlmostFull  = (w_fill >= AFULL_C);
  assign fifo_AlmostEmpty = (w_fill <= AEMPTY_C);
  assign overflow         = r_overflow;
  assign underflow        = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one standard-read instance and one
// FWFT instance sharing clock and reset, each with its own stimulus.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst_n;

  logic [7:0] s_wdata, s_rdata;
  logic       s_w, s_r, s_clr;
  logic       s_rvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic [5:0] s_cnt;

  logic [7:0] f_wdata, f_rdata;
  logic       f_w, f_r, f_clr;
  logic       f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [5:0] f_cnt;

  // Flag vectors: {full, empty, afull, aempty, valid, overflow, underflow}
  logic [6:0] s_flags, f_flags;
  assign s_flags = {s_full, s_empty, s_afull, s_aempty, s_rvalid, s_ovf, s_unf};
  assign f_flags = {f_full, f_empty, f_afull, f_aempty, f_rvalid, f_ovf, f_unf};

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo_flags #(
    .data_Size(8), .address_Size(5), .AFULL_Thresh(28), .AEMPTY_Thresh(4), .FWFT(0)
  ) u_std (
    .Clk(clk), .Rst(rst_n), .write_Data(s_wdata), .w_Inc(s_w), .r_Inc(s_r),
    .clr_Err(s_clr), .read_Data(s_rdata), .read_Valid(s_rvalid),
    .fifo_Full(s_full), .fifo_Empty(s_empty), .fifo_AlmostFull(s_afull),
    .fifo_AlmostEmpty(s_aempty), .fill_Count(s_cnt), .overflow(s_ovf),
    .underflow(s_unf)
  );

  sync_fifo_flags #(
    .data_Size(8), .address_Size(5), .AFULL_Thresh(28), .AEMPTY_Thresh(4), .FWFT(1)
  ) u_fwft (
    .Clk(clk), .Rst(rst_n), .write_Data(f_wdata), .w_Inc(f_w), .r_Inc(f_r),
    .clr_Err(f_clr), .read_Data(f_rdata), .read_Valid(f_rvalid),
    .fifo_Full(f_full), .fifo_Empty(f_empty), .fifo_AlmostFull(f_afull),
    .fifo_AlmostEmpty(f_aempty), .fill_Count(f_cnt), .overflow(f_ovf),
    .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus on the standard instance; returns 1 time unit
  // after the edge with inputs idle again.
  task automatic s_op(input logic w, input logic r, input logic [7:0] d, input logic c);
    s_w = w; s_r = r; s_wdata = d; s_clr = c;
    @(posedge clk); #1;
    s_w = 1'b0; s_r = 1'b0; s_clr = 1'b0;
  endtask

  task automatic f_op(input logic w, input logic r, input logic [7:0] d, input logic c);
    f_w = w; f_r = r; f_wdata = d; f_clr = c;
    @(posedge clk); #1;
    f_w = 1'b0; f_r = 1'b0; f_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #7;
    n_cmp++; if (s_flags !== 7'b0101000) begin n_err++; $display("FAIL reset_std_flags: got %b want 0101000", s_flags); end
    n_cmp++; if (s_cnt !== 6'd0) begin n_err++; $display("FAIL reset_std_count: got %0d want 0", s_cnt); end
    n_cmp++; if (s_rdata !== 8'h00) begin n_err++; $display("FAIL reset_std_rdata: got %h want 00", s_rdata); end
    n_cmp++; if (f_flags !== 7'b0101000) begin n_err++; $display("FAIL reset_fwft_flags: got %b want 0101000", f_flags); end
    n_cmp++; if (f_cnt !== 6'd0) begin n_err++; $display("FAIL reset_fwft_count: got %0d want 0", f_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    s_op(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if ({s_flags, s_cnt} !== {7'b0101000, 6'd0}) begin n_err++; $display("FAIL idle_std: got %b/%0d want 0101000/0", s_flags, s_cnt); end
  endtask

  task automatic test_std_basic;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) s_op(1'b1, 1'b0, exp_d[i], 1'b0);
    n_cmp++; if ({s_flags, s_cnt} !== {7'b0001000, 6'd3}) begin n_err++; $display("FAIL basic_after_writes: got %b/%0d want 0001000/3", s_flags, s_cnt); end
    for (int i = 0; i < 3; i++) begin
      s_op(1'b0, 1'b1, 8'h00, 1'b0);
      n_cmp++; if ({s_rvalid, s_rdata} !== {1'b1, exp_d[i]}) begin n_err++; $display("FAIL basic_read%0d: got v=%b d=%h want v=1 d=%h", i, s_rvalid, s_rdata, exp_d[i]); end
      n_cmp++; if (s_cnt !== 6'(2 - i)) begin n_err++; $display("FAIL basic_count%0d: got %0d want %0d", i, s_cnt, 2 - i); end
    end
    s_op(1'b0, 1'b0, 8'h00, 1'b0);
    n_cmp++; if ({s_flags, s_rdata} !== {7'b0101000, 8'h33}) begin n_err++; $display("FAIL basic_idle_hold: got %b/%h want 0101000/33", s_flags, s_rdata); end
  endtask

  task automatic test_full;
    logic [7:0] d;
    for (int i = 0; i < 32; i++) begin
      d = 8'h40 + 8'(i);
      s_op(1'b1, 1'b0, d, 1'b0);
      n_cmp++; if ({s_afull, s_full} !== {(i + 1) >= 28, (i + 1) == 32}) begin n_err++; $display("FAIL fill_flags_w%0d: got afull=%b full=%b", i + 1, s_afull, s_full); end
    end
    n_cmp++; if (s_cnt !== 6'd32) begin n_err++; $display("FAIL fill_count32: got %0d want 32", s_cnt); end
    s_op(1'b1, 1'b0, 8'hFF, 1'b0);
    n_cmp++; if ({s_flags, s_cnt} !== {7'b1010010, 6'd32}) begin n_err++; $display("FAIL overflow_write: got %b/%0d want 1010010/32", s_flags, s_cnt); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] e;
    // From full: read accepted, write rejected.
    s_op(1'b1, 1'b1, 8'hEE, 1'b0);
    n_cmp++; if ({s_rvalid, s_rdata} !== {1'b1, 8'h40}) begin n_err++; $display("FAIL full_rw_data: got v=%b d=%h want v=1 d=40", s_rvalid, s_rdata); end
    n_cmp++; if ({s_flags, s_cnt} !== {7'b0010110, 6'd31}) begin n_err++; $display("FAIL full_rw_state: got %b/%0d want 0010110/31", s_flags, s_cnt); end
    for (int i = 0; i < 21; i++) begin
      e = 8'h41 + 8'(i);
      s_op(1'b0, 1'b1, 8'h00, 1'b0);
      n_cmp++; if (s_rdata !== e) begin n_err++; $display("FAIL drain_a%0d: got %h want %h", i, s_rdata, e); end
    end
    n_cmp++; if (s_cnt !== 6'd10) begin n_err++; $display("FAIL count10: got %0d want 10", s_cnt); end
    s_op(1'b1, 1'b1, 8'h77, 1'b0);
    n_cmp++; if ({s_rdata, s_cnt} !== {8'h56, 6'd10}) begin n_err++; $display("FAIL mid_rw: got %h/%0d want 56/10", s_rdata, s_cnt); end
    for (int i = 0; i < 10; i++) begin
      e = (i < 9) ? 8'h57 + 8'(i) : 8'h77;
      s_op(1'b0, 1'b1, 8'h00, 1'b0);
      n_cmp++; if (s_rdata !== e) begin n_err++; $display("FAIL drain_b%0d: got %h want %h", i, s_rdata, e); end
    end
    n_cmp++; if ({s_empty, s_cnt} !== {1'b1, 6'd0}) begin n_err++; $display("FAIL drained: got e=%b c=%0d want e=1 c=0", s_empty, s_cnt); end
  endtask

  task automatic test_errors;
    s_op(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if ({s_ovf, s_unf} !== 2'b00) begin n_err++; $display("FAIL clr_ovf: got %b%b want 00", s_ovf, s_unf); end
    s_op(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if ({s_flags, s_cnt} !== {7'b0101001, 6'd0}) begin n_err++; $display("FAIL underflow_set: got %b/%0d want 0101001/0", s_flags, s_cnt); end
    s_op(1'b0, 1'b0, 8'h00, 1'b1);
    n_cmp++; if (s_unf !== 1'b0) begin n_err++; $display("FAIL underflow_clr: got %b want 0", s_unf); end
    s_op(1'b0, 1'b1, 8'h00, 1'b1);
    n_cmp++; if (s_unf !== 1'b1) begin n_err++; $display("FAIL set_beats_clr: got %b want 1", s_unf); end
    // Write and read together while empty: write lands, read is rejected.
    s_op(1'b1, 1'b1, 8'h99, 1'b0);
    n_cmp++; if ({s_flags, s_cnt} !== {7'b0001001, 6'd1}) begin n_err++; $display("FAIL empty_rw: got %b/%0d want 0001001/1", s_flags, s_cnt); end
    s_op(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if ({s_rvalid, s_rdata, s_cnt} !== {1'b1, 8'h99, 6'd0}) begin n_err++; $display("FAIL ptr_unmoved: got v=%b d=%h c=%0d want 1/99/0", s_rvalid, s_rdata, s_cnt); end
  endtask

  task automatic test_fwft;
    logic [7:0] q [$];
    logic       wr, rd, wr_ok, rd_ok;
    logic [7:0] d;
    f_op(1'b1, 1'b0, 8'hA5, 1'b0);
    n_cmp++; if ({f_rvalid, f_rdata, f_cnt} !== {1'b1, 8'hA5, 6'd1}) begin n_err++; $display("FAIL fwft_first: got v=%b d=%h c=%0d want 1/a5/1", f_rvalid, f_rdata, f_cnt); end
    f_op(1'b0, 1'b1, 8'h00, 1'b0);
    n_cmp++; if ({f_rvalid, f_cnt} !== {1'b0, 6'd0}) begin n_err++; $display("FAIL fwft_ack: got v=%b c=%0d want 0/0", f_rvalid, f_cnt); end
    // Mixed traffic: ~120 accepted writes, wrapping the pointers over 3 times.
    for (int i = 0; i < 160; i++) begin
      n_cmp++; if ({f_rvalid, f_cnt} !== {q.size() != 0, 6'(q.size())}) begin n_err++; $display("FAIL mix_state%0d: got v=%b c=%0d want c=%0d", i, f_rvalid, f_cnt, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if (f_rdata !== q[0]) begin n_err++; $display("FAIL mix_data%0d: got %h want %h", i, f_rdata, q[0]); end
      end
      wr = (i % 4) != 3;
      rd = (i % 3) != 0;
      d  = 8'(i * 7 + 3);
      wr_ok = wr && (q.size() < 32);
      rd_ok = rd && (q.size() > 0);
      f_op(wr, rd, d, 1'b0);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(d);
    end
    // Asynchronous reset between edges clears everything immediately.
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({f_flags, f_cnt} !== {7'b0101000, 6'd0}) begin n_err++; $display("FAIL async_rst_fwft: got %b/%0d want 0101000/0", f_flags, f_cnt); end
    n_cmp++; if ({s_flags, s_cnt, s_rdata} !== {7'b0101000, 6'd0, 8'h00}) begin n_err++; $display("FAIL async_rst_std: got %b/%0d/%h want 0101000/0/00", s_flags, s_cnt, s_rdata); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    f_op(1'b1, 1'b0, 8'h5A, 1'b0);
    n_cmp++; if ({f_rvalid, f_rdata, f_cnt} !== {1'b1, 8'h5A, 6'd1}) begin n_err++; $display("FAIL post_rst_write: got v=%b d=%h c=%0d want 1/5a/1", f_rvalid, f_rdata, f_cnt); end
  endtask

  initial begin
    s_w = 1'b0; s_r = 1'b0; s_clr = 1'b0; s_wdata = '0;
    f_w = 1'b0; f_r = 1'b0; f_clr = 1'b0; f_wdata = '0;
    test_reset();
    test_std_basic();
    test_full();
    test_simultaneous();
    test_errors();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
